// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: state encoding and default widths.
package counter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int unsigned DEF_WIDTH      = 4;
  localparam int unsigned DEF_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StRun    = ST_RUN,
    StPaused = ST_PAUSED,
    StDone   = ST_DONE
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: one tick every (prescale+1) enabled cycles; holds while disabled.
module tick_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_d, pre_cnt_q;

  // >= rather than == so a lowered prescale takes effect without waiting for a wrap.
  assign tick = en && (pre_cnt_q >= prescale);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable, prescaled down-counter/timer with one-shot or auto-reload terminal count.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  tc
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] count_d, count_q;
  logic [WIDTH-1:0] reload_d, reload_q;
  logic             tc_d, tc_q;
  logic             tick;
  logic             pre_en, pre_clr;

  // Prescaler advances only on cycles where RUN is not overridden by load or stop.
  assign pre_en  = (state_q == StRun) && !load && !stop;
  assign pre_clr = load || (start && !stop && (state_q == StDone));

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (pre_en),
    .clr     (pre_clr),
    .prescale(prescale),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = StIdle;
    end else if (stop) begin
      if (state_q == StRun) state_d = StPaused;
    end else if (start && (state_q != StRun)) begin
      if (state_q == StDone) count_d = reload_q;
      state_d = StRun;
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (auto_reload) begin
        count_d = reload_q;
        tc_d    = 1'b1;
      end else begin
        count_d = '0;
        tc_d    = 1'b1;
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed, table-driven bench for down_counter_timer with hand-computed expectations.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] prescale = '0;
  logic [3:0] count;
  logic       busy, done, tc;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       st;
    logic       sp;
    logic       ar;
    logic [7:0] pre;
    logic [3:0] e_count;
    logic       e_busy;
    logic       e_done;
    logic       e_tc;
  } vec_t;

  vec_t vecs[$];

  down_counter_timer #(
    .WIDTH(4),
    .PRESCALE_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .prescale   (prescale),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  function automatic void add(logic ld, logic [3:0] lv, logic st, logic sp, logic ar,
                              logic [7:0] pre, logic [3:0] ec, logic eb, logic ed, logic et);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.ar = ar; v.pre = pre;
    v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_tc = et;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [3:0] ec, logic eb, logic ed, logic et);
    n_vec++;
    if (count !== ec || busy !== eb || done !== ed || tc !== et) begin
      n_bad++;
      $display("FAIL %s: got count=%0d busy=%b done=%b tc=%b, want count=%0d busy=%b done=%b tc=%b",
               name, count, busy, done, tc, ec, eb, ed, et);
    end
  endtask

  // Apply inputs for one clock edge, then sample 1 time unit after the edge.
  task automatic step(logic ld, logic [3:0] lv, logic st, logic sp, logic ar, logic [7:0] pre);
    load = ld; load_value = lv; start = st; stop = sp; auto_reload = ar; prescale = pre;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    // One-shot countdown from 5
    add(1, 5, 0, 0, 0, 0, 5, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 5, 1, 0, 0);
    for (int c = 4; c >= 1; c--) add(0, 0, 0, 0, 0, 0, 4'(c), 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Auto-reload period 3
    add(1, 3, 0, 0, 1, 0, 3, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 3, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      add(0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0, 3, 1, 0, 1);
    end
    // load beats start in RUN, then run one-shot to DONE
    add(1, 9, 1, 0, 1, 0, 9, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 9, 1, 0, 0);
    for (int c = 8; c >= 1; c--) add(0, 0, 0, 0, 0, 0, 4'(c), 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // stop and start+stop in DONE do nothing; start alone reloads 9
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 9, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8, 1, 0, 0);
    // Loaded zero with auto-reload: tc every tick
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

    // Reset for 2 cycles
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].ar, vecs[i].pre);
      check($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy, vecs[i].e_done,
            vecs[i].e_tc);
    end

    // Prescale 2: one step every 3 cycles, tc 12 cycles after start
    step(1, 4, 0, 0, 0, 2);
    step(0, 0, 1, 0, 0, 2);
    check("pre_start", 4, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 0, 0, 2);
      check($sformatf("pre_k%0d", k), 4'(4 - k / 3), (k != 12), (k == 12), (k == 12));
    end

    // Pause at 6, hold, start+stop stays paused, start resumes
    step(1, 9, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    check("at6", 6, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("stop", 6, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0, 0, 0);
      check($sformatf("hold%0d", k), 6, 0, 0, 0);
    end
    step(0, 0, 1, 1, 0, 0);
    check("start_stop", 6, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("resume", 6, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("resume5", 5, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("resume4", 4, 1, 0, 0);

    // Async reset right after a tc pulse clears everything immediately
    step(1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("tc_pending", 1, 1, 0, 1);
    reset = 1'b1;
    #1;
    check("reset_mid", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 1, 0, 0, 0);
    check("after_reset", 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
